// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the decoded key outputs.
interface keypad_scanner_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  modport master (input col, output row, key, key_valid, key_held);
  modport slave (output col, input row, key, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scan with press/release debounce and a one-cycle key strobe.
module keypad_scanner #(
  parameter int SCAN_DIV       = 48000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input logic              int_osc,
  input logic              reset,
  keypad_scanner_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_SCANS - 1);
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
  state_t        state_q, state_d;
  logic [3:0]    sync1_q, col_s_q;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d, rel_cnt_q, rel_cnt_d;
  logic [1:0]    r_q, r_d, c_q, c_d, c_enc;
  logic [3:0]    key_q, key_d, col_low, cand;
  logic          key_valid_q, key_valid_d, tick, one_low, cand_high;
  assign tick      = div_cnt_q == DIV_LAST;
  assign col_low   = ~col_s_q;
  assign one_low   = (col_low != 4'b0) && ((col_low & (col_low - 4'd1)) == 4'b0);
  assign c_enc     = col_low[1] ? 2'd1 : col_low[2] ? 2'd2 : col_low[3] ? 2'd3 : 2'd0;
  assign cand      = ~(4'b0001 << c_q);
  assign cand_high = col_s_q[c_q];
  // Counters stop one short of DEBOUNCE_SCANS: the final matching tick acts instead of incrementing.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    deb_cnt_d   = deb_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    div_cnt_d   = tick ? '0 : div_cnt_q + DW'(1);
    if (tick)
      case (state_q)
        SCAN:
          if (one_low) begin
            state_d   = DEBOUNCE;
            c_d       = c_enc;
            deb_cnt_d = CW'(1);
          end else
            r_d = r_q + 2'd1;
        DEBOUNCE:
          if (col_s_q != cand) begin
            state_d = SCAN;
            r_d     = r_q + 2'd1;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_d     = HELD;
            key_d       = KEY_MAP[{r_q, c_q, 2'b00} +: 4];
            key_valid_d = 1'b1;
          end else
            deb_cnt_d = deb_cnt_q + CW'(1);
        HELD:
          if (cand_high) begin
            state_d   = RELEASE;
            rel_cnt_d = CW'(1);
          end
        RELEASE:
          if (!cand_high)
            state_d = HELD;
          else if (rel_cnt_q == DEB_LAST) begin
            state_d = SCAN;
            r_d     = r_q + 2'd1;
          end else
            rel_cnt_d = rel_cnt_q + CW'(1);
        default: state_d = SCAN;
      endcase
  end
  always_ff @(posedge int_osc or posedge reset)
    if (reset) begin
      state_q     <= SCAN;
      sync1_q     <= 4'hF;
      col_s_q     <= 4'hF;
      div_cnt_q   <= '0;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      r_q         <= 2'd0;
      c_q         <= 2'd0;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= kp.col;
      col_s_q     <= sync1_q;
      div_cnt_q   <= div_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      r_q         <= r_d;
      c_q         <= c_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
    end
  assign kp.row       = ~(4'b0001 << r_q);
  assign kp.key       = key_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = (state_q == HELD) || (state_q == RELEASE);
endmodule
